// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Sequential instruction fetch. Holds the PC, reads the
//             instruction memory combinationally and buffers {pc, instr}
//             pairs in a small FIFO toward decode. A taken branch flushes
//             the buffer and restarts fetch at the word-aligned target.
//  Options  : FETCH_PERF_CNT_EN adds perf_fetched, a saturating count of
//             instructions handed to decode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic [5:0]    imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_instr,
  output logic [N-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched
`endif
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  logic [N-1:0]       pc_q,      pc_d;
  logic [C_CNT_W-1:0] count_q,   count_d;
  logic [C_PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [N-1:0]       pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];

  logic w_full;
  logic w_deq;
  logic w_enq;
  logic w_unused_ok;

  // Only bits [N-1:2] of the branch target matter; the byte offset is dropped.
  assign w_unused_ok = &{1'b0, br_target[1:0]};

  assign w_full    = (count_q == C_CNT_W'(DEPTH));
  assign if_valid  = (count_q != '0);
  // A redirect overrides any handshake in the same cycle.
  assign w_deq     = if_valid && if_ready && !br_taken;
  assign w_enq     = !br_taken && (!w_full || w_deq);
  assign imem_addr = pc_q[7:2];
  assign if_pc     = pc_mem_q[rd_ptr_q];
  assign if_instr  = instr_mem_q[rd_ptr_q];

  // Next-state for PC, occupancy and pointers; redirect beats everything.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (br_taken) begin
      pc_d     = {br_target[N-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_enq) begin
        pc_d     = pc_q + N'(4);
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_deq) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      count_d = count_q + C_CNT_W'(w_enq) - C_CNT_W'(w_deq);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (w_enq) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of accepted transfers; survives redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (w_deq && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetched = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed bench for fetch_unit with an expected-transfer
//             scoreboard and direct checks at notable points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_taken;
  logic [63:0] br_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
`endif

  logic [31:0] mem [64];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_xfer   = 0;

  always #5 clk = ~clk;

  assign imem_q = mem[imem_addr];

  fetch_unit #(.N(64), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    exp_t        e;
    logic [63:0] a;
    for (int i = 0; i < n; i++) begin
      a       = start + 64'(4 * i);
      e.pc    = a;
      e.instr = mem[a[7:2]];
      sb.push_back(e);
    end
  endtask

  // Score any transfer about to happen at the coming edge, then advance.
  task automatic tick();
    exp_t e;
    if (if_valid && if_ready && !br_taken && !reset) begin
      n_xfer++;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL sb_underflow: observed pc %h expected none", if_pc);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", if_pc, e.pc);
        chk("xfer_instr", {32'h0, if_instr}, {32'h0, e.instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h5A00_0000 + 32'(k) * 32'h0001_0101;
    mem[0]  = 32'hf800_0000;
    mem[1]  = 32'hf800_8001;
    mem[2]  = 32'hf801_0002;
    mem[15] = 32'hcb0e_01ce;

    reset     = 1'b1;
    if_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_pc", if_pc, 64'h0);
    chk("rst_instr", {32'h0, if_instr}, 64'h0);
    chk("rst_addr", {58'h0, imem_addr}, 64'h0);

    // Streaming with decode always ready.
    if_ready = 1'b1;
    push_seq(64'h0, 8);
    reset = 1'b0;
    tick();
    chk("lat_valid", {63'h0, if_valid}, 64'h1);
    chk("lat_pc", if_pc, 64'h0);
    chk("lat_instr", {32'h0, if_instr}, 64'hf800_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_valid", {63'h0, if_valid}, 64'h1);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("perf_before", {32'h0, perf_fetched}, 64'd3);
`endif
    // Asynchronous reset with entries buffered.
    reset = 1'b1;
    #1;
    chk("midrst_valid", {63'h0, if_valid}, 64'h0);
    chk("midrst_pc", if_pc, 64'h0);
    chk("midrst_instr", {32'h0, if_instr}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_after", {32'h0, perf_fetched}, 64'd0);
`endif
    n_xfer = 0;
    sb.delete();
    if_ready = 1'b0;
    tick();
    reset = 1'b0;
    push_seq(64'h0, 8);

    // Back-pressure fills the buffer and freezes the PC.
    repeat (5) tick();
    chk("bp_addr", {58'h0, imem_addr}, 64'd2);
    chk("bp_valid", {63'h0, if_valid}, 64'h1);
    chk("bp_pc", if_pc, 64'h0);
    if_ready = 1'b1;
    repeat (3) tick();
    if_ready = 1'b0;
    repeat (2) tick();
    chk("full_addr", {58'h0, imem_addr}, 64'd5);
    chk("full_pc", if_pc, 64'hC);

    // Redirect while full.
    br_taken  = 1'b1;
    br_target = 64'h3C;
    sb.delete();
    push_seq(64'h3C, 8);
    tick();
    br_taken = 1'b0;
    chk("redir_flush", {63'h0, if_valid}, 64'h0);
    tick();
    chk("redir_valid", {63'h0, if_valid}, 64'h1);
    chk("redir_pc", if_pc, 64'h3C);
    chk("redir_instr", {32'h0, if_instr}, 64'hcb0e_01ce);

    // Unaligned target with a concurrent handshake that must be dropped.
    if_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 64'h3F;
    sb.delete();
    push_seq(64'h3C, 8);
    tick();
    br_taken = 1'b0;
    chk("unal_flush", {63'h0, if_valid}, 64'h0);
    tick();
    chk("unal_pc", if_pc, 64'h3C);
    repeat (2) tick();

    // Back-to-back redirects: the later one wins.
    br_taken  = 1'b1;
    br_target = 64'h80;
    tick();
    br_target = 64'h10;
    tick();
    br_taken = 1'b0;
    sb.delete();
    push_seq(64'h10, 8);
    chk("b2b_flush", {63'h0, if_valid}, 64'h0);
    repeat (3) tick();

    // Word index wraps past the top of the 64-word memory.
    br_taken  = 1'b1;
    br_target = 64'hFC;
    tick();
    br_taken = 1'b0;
    sb.delete();
    push_seq(64'hFC, 4);
    chk("wrap_addr63", {58'h0, imem_addr}, 64'd63);
    tick();
    chk("wrap_addr0", {58'h0, imem_addr}, 64'd0);
    chk("wrap_pc", if_pc, 64'hFC);
    repeat (2) tick();
    chk("wrap_sb_left", 64'(sb.size()), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
